// File: rtl/aes_key_sched_iter_pkg.sv
// Shared AES constants and helpers for the iterative key schedule.
package aes_key_sched_iter_pkg;

    localparam int NR_128 = 10;   // rounds for AES-128
    localparam int KEY_W  = 128;  // cipher key width
    localparam int WORD_W = 32;   // key schedule word width

    typedef logic [WORD_W-1:0] word_t;

    // Per-cycle action of the key schedule, decoded from kld/adv/done.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_ADV  = 2'd2
    } op_e;

    // RotWord(a,b,c,d) = (b,c,d,a), byte a in the top of the word.
    function automatic word_t rot_word(input word_t a);
        return {a[23:0], a[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sched_iter_if.sv
// Handshake/data bundle between the key schedule, its controller and the
// round-constant generator.
interface aes_key_sched_iter_if;
    import aes_key_sched_iter_pkg::*;

    logic             kld;       // key load strobe
    logic [KEY_W-1:0] key;       // cipher key, word 0 in [127:96]
    logic             adv;       // request next round key
    logic [31:0]      rcon;      // round constant, only [31:24] used
    logic             rcon_en;   // step the round-constant generator
    word_t            wo_0;      // current round key words
    word_t            wo_1;
    word_t            wo_2;
    word_t            wo_3;
    logic [3:0]       round;     // index of the round key on wo_*
    logic             rk_valid;  // new round key just appeared
    logic             done;      // round == NR

    // Controller / generator side.
    modport master (
        output kld, key, adv, rcon,
        input  rcon_en, wo_0, wo_1, wo_2, wo_3, round, rk_valid, done
    );

    // Key schedule side.
    modport slave (
        input  kld, key, adv, rcon,
        output rcon_en, wo_0, wo_1, wo_2, wo_3, round, rk_valid, done
    );

endinterface

// File: rtl/aes_key_sched_iter_sbox.sv
// AES forward S-box, purely combinational byte substitution.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_d
);

    // Index 0 sits in the most significant byte of the constant.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup.
    assign o_d = SBOX[i_a];

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128 key schedule: load a cipher key, then emit one round key
// per advance cycle, keeping the external round-constant generator in step.
module aes_key_sched_iter
    import aes_key_sched_iter_pkg::*;
#(
    // Only AES-128 (10 rounds) is supported.
    parameter int NR = NR_128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    aes_key_sched_iter_if.slave       bus
);

    localparam logic [3:0] NR_L = 4'(NR);

    // Round key state.
    word_t      r_w0;
    word_t      r_w1;
    word_t      r_w2;
    word_t      r_w3;
    logic [3:0] r_round;
    logic       r_rk_valid;
    logic       r_done;

    // Next-key datapath.
    op_e        w_op;
    word_t      w_rot;
    word_t      w_sub;
    word_t      w_t;
    word_t      w_n0;
    word_t      w_n1;
    word_t      w_n2;
    word_t      w_n3;
    logic [3:0] w_round_inc;

    // The generator drives a full word; only its top byte carries the constant.
    logic       w_unused_rcon;
    assign w_unused_rcon = ^bus.rcon[23:0];

    // Decode this cycle's action; load wins over advance, advance stops at done.
    always_comb begin
        // NOTE: default first so every path assigns w_op and no latch is inferred.
        w_op = OP_HOLD;
        if (bus.kld) begin
            w_op = OP_LOAD;
        end else if (bus.adv && !r_done) begin
            w_op = OP_ADV;
        end
    end

    // The generator steps exactly when this block consumes a constant.
    assign bus.rcon_en = (w_op == OP_ADV);

    // SubWord(RotWord(w3)) using one S-box per byte.
    assign w_rot = rot_word(r_w3);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_a (w_rot[8*g +: 8]),
            .o_d (w_sub[8*g +: 8])
        );
    end

    // Chain of XORs producing the next four words.
    assign w_t         = w_sub ^ {bus.rcon[31:24], 24'h0};
    assign w_n0        = r_w0 ^ w_t;
    assign w_n1        = r_w1 ^ w_n0;
    assign w_n2        = r_w2 ^ w_n1;
    assign w_n3        = r_w3 ^ w_n2;
    assign w_round_inc = r_round + 4'd1;

    // Round-key registers: load, advance or hold; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w0       <= '0;
            r_w1       <= '0;
            r_w2       <= '0;
            r_w3       <= '0;
            r_round    <= '0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_rk_valid <= 1'b0;
            case (w_op)
                OP_LOAD: begin
                    r_w0       <= bus.key[127:96];
                    r_w1       <= bus.key[95:64];
                    r_w2       <= bus.key[63:32];
                    r_w3       <= bus.key[31:0];
                    r_round    <= '0;
                    r_done     <= 1'b0;
                    r_rk_valid <= 1'b1;
                end
                OP_ADV: begin
                    r_w0       <= w_n0;
                    r_w1       <= w_n1;
                    r_w2       <= w_n2;
                    r_w3       <= w_n3;
                    r_round    <= w_round_inc;
                    r_done     <= (w_round_inc == NR_L);
                    r_rk_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs come straight from registers.
    assign bus.wo_0     = r_w0;
    assign bus.wo_1     = r_w1;
    assign bus.wo_2     = r_w2;
    assign bus.wo_3     = r_w3;
    assign bus.round    = r_round;
    assign bus.rk_valid = r_rk_valid;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Directed bench for the iterative AES-128 key schedule with a small
// round-constant generator model alongside.
module tb_aes_key_sched_iter;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    aes_key_sched_iter_if u_if ();

    aes_key_sched_iter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Round-constant generator: 0x01 after reset/load, xtime on each enable.
    logic [7:0] r_gen;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen <= 8'h01;
        end else if (u_if.kld) begin
            r_gen <= 8'h01;
        end else if (u_if.rcon_en) begin
            r_gen <= {r_gen[6:0], 1'b0} ^ (r_gen[7] ? 8'h1b : 8'h00);
        end
    end
    // Junk in the low bits, which the schedule must ignore.
    assign u_if.rcon = {r_gen, 24'ha5c35a};

    function automatic logic [127:0] wo_all();
        return {u_if.wo_0, u_if.wo_1, u_if.wo_2, u_if.wo_3};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        u_if.kld = 1'b1;
        u_if.key = k;
        step();
        u_if.kld = 1'b0;
    endtask

    task automatic advance(input int n);
        u_if.adv = 1'b1;
        repeat (n) step();
        u_if.adv = 1'b0;
    endtask

    initial begin
        u_if.kld = 1'b0;
        u_if.adv = 1'b0;
        u_if.key = '0;

        // Reset and idle.
        #2 rst_n = 1'b0;
        #1;
        check("reset_wo", wo_all(), '0);
        check("reset_round", 128'(u_if.round), 128'd0);
        check("reset_done", 128'(u_if.done), 128'd0);
        check("reset_rk_valid", 128'(u_if.rk_valid), 128'd0);
        #4 rst_n = 1'b1;
        step();
        step();
        check("idle_wo", wo_all(), '0);
        check("idle_rk_valid", 128'(u_if.rk_valid), 128'd0);

        // Advance without a prior load: all-zero state, saturates at round 10.
        advance(12);
        check("noload_round", 128'(u_if.round), 128'd10);
        check("noload_done", 128'(u_if.done), 128'd1);
        check("noload_wo", wo_all(), ZERO_R10);

        // FIPS-197 key.
        load(FIPS_KEY);
        check("fips_load_wo", wo_all(), FIPS_KEY);
        check("fips_load_round", 128'(u_if.round), 128'd0);
        check("fips_load_done", 128'(u_if.done), 128'd0);
        check("fips_load_rk_valid", 128'(u_if.rk_valid), 128'd1);
        advance(1);
        check("fips_r1_wo", wo_all(), FIPS_R1);
        check("fips_r1_round", 128'(u_if.round), 128'd1);
        check("fips_r1_rk_valid", 128'(u_if.rk_valid), 128'd1);
        advance(9);
        check("fips_r10_wo", wo_all(), FIPS_R10);
        check("fips_r10_round", 128'(u_if.round), 128'd10);
        check("fips_r10_done", 128'(u_if.done), 128'd1);

        // Eleventh advance is ignored.
        u_if.adv = 1'b1;
        #1;
        check("extra_adv_rcon_en", 128'(u_if.rcon_en), 128'd0);
        step();
        u_if.adv = 1'b0;
        check("extra_adv_wo", wo_all(), FIPS_R10);
        check("extra_adv_round", 128'(u_if.round), 128'd10);
        check("extra_adv_rk_valid", 128'(u_if.rk_valid), 128'd0);

        // All-zero key.
        load('0);
        advance(1);
        check("zero_r1_wo", wo_all(), ZERO_R1);
        advance(9);
        check("zero_r10_wo", wo_all(), ZERO_R10);
        check("zero_r10_done", 128'(u_if.done), 128'd1);

        // Reload with adv on the same edge at round 5.
        load(FIPS_KEY);
        advance(5);
        check("mid_round5", 128'(u_if.round), 128'd5);
        u_if.kld = 1'b1;
        u_if.adv = 1'b1;
        u_if.key = '0;
        #1;
        check("reload_rcon_en", 128'(u_if.rcon_en), 128'd0);
        step();
        u_if.kld = 1'b0;
        u_if.adv = 1'b0;
        check("reload_wo", wo_all(), '0);
        check("reload_round", 128'(u_if.round), 128'd0);
        advance(1);
        check("reload_r1_wo", wo_all(), ZERO_R1);
        check("reload_r1_round", 128'(u_if.round), 128'd1);

        // Asynchronous reset between edges at round 7.
        load(FIPS_KEY);
        advance(7);
        check("pre_reset_round", 128'(u_if.round), 128'd7);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_wo", wo_all(), '0);
        check("async_reset_round", 128'(u_if.round), 128'd0);
        check("async_reset_rk_valid", 128'(u_if.rk_valid), 128'd0);
        #2 rst_n = 1'b1;
        step();

        // Full schedule again after reset.
        load(FIPS_KEY);
        advance(10);
        check("post_reset_r10_wo", wo_all(), FIPS_R10);
        check("post_reset_done", 128'(u_if.done), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
